// File: rtl/mux_n_1_rr.sv
// mux_n_1_rr: N-input, W-bit round-robin arbitrating multiplexer with
// valid/ready handshakes on every input and a registered output stage.
// The output register accepts a new word whenever it is empty or being
// drained in the same cycle, so a continuously ready consumer sees one
// word per clock.
//
// Optional build macro: MUX_N_1_RR_PACKET_LOCK_EN
//   Defined   - once a channel is granted, the arbiter stays on it until
//               that channel delivers a word with in_last set.
//   Undefined - arbitration happens afresh for every word; in_last is only
//               carried through to out_last.
module mux_n_1_rr #(
    parameter int N  = 4,
    parameter int W  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_last,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic           out_last,
    output logic [SW-1:0]  out_sel
);

    // Round-robin start point: the channel just after the last one served.
    logic [SW-1:0] ptr;

    logic          ld;        // output register may take a new word
    logic [N-1:0]  cand;      // channels allowed to compete this cycle
    logic          found;     // at least one candidate exists
    logic [SW-1:0] gnt;       // winning channel
    logic [W-1:0]  gnt_data;  // winning channel's word
    logic          gnt_last;  // winning channel's end-of-packet flag
    logic          accept;    // handshake completes on the granted channel
    logic [SW-1:0] ptr_next;  // pointer value after serving gnt

`ifdef MUX_N_1_RR_PACKET_LOCK_EN
    // Set while a packet is in flight. The locked channel is always the
    // one in out_sel, because out_sel only changes on an accept.
    logic lock;
`endif

    // Restrict competing channels to the locked one while a packet is open.
    always_comb begin
        cand = in_valid;
`ifdef MUX_N_1_RR_PACKET_LOCK_EN
        if (lock) begin
            cand          = '0;
            cand[out_sel] = in_valid[out_sel];
        end
`endif
    end

    // Scan the candidates cyclically from ptr and pick the first one found.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        found    = 1'b0;
        gnt      = '0;
        gnt_data = '0;
        gnt_last = 1'b0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && cand[idx]) begin
                found    = 1'b1;
                gnt      = SW'(idx);
                gnt_data = in_data[idx*W +: W];
                gnt_last = in_last[idx];
            end
        end
    end

    // Handshake: one-hot ready to the winner only when the register can load.
    always_comb begin
        ld       = !out_valid || out_ready;
        accept   = rst_n && ld && found;
        in_ready = '0;
        if (accept) in_ready[gnt] = 1'b1;
        ptr_next = (gnt == SW'(N-1)) ? '0 : gnt + SW'(1);
    end

    // Output register, round-robin pointer and packet lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sel   <= '0;
            ptr       <= '0;
`ifdef MUX_N_1_RR_PACKET_LOCK_EN
            lock      <= 1'b0;
`endif
        end else if (accept) begin
            // NOTE: state updates use non-blocking assignments so every
            // register samples values from before this edge.
            out_valid <= 1'b1;
            out_data  <= gnt_data;
            out_last  <= gnt_last;
            out_sel   <= gnt;
`ifdef MUX_N_1_RR_PACKET_LOCK_EN
            lock      <= !gnt_last;
            if (gnt_last) ptr <= ptr_next;
`else
            ptr       <= ptr_next;
`endif
        end else if (ld) begin
            // Drained with nothing to replace it: mark empty, keep fields.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/mux_n_1_rr.md
# mux_n_1_rr

Parametrised N-input, W-bit round-robin arbitrating multiplexer with valid/ready handshakes on every input and on the output. It is the sequential successor of the fixed 4:1 combinational mux: selection is made by a fair arbiter instead of an external `sel`, and the chosen word is captured in an output register. It sits between several producer streams and a single consumer.

## Interface

- `N`, default 4: number of input channels; legal range 2..16.
- `W`, default 4: data width in bits; minimum 1.
- `SW`, default `$clog2(N)`: width of the channel-id output; derived, never overridden.

Ports, clock and reset first:

- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  N  bit i set means channel i offers a word.
- `in_ready`  out  N  bit i set means channel i's word is accepted this cycle.
- `in_data`  in  N*W  channel i occupies bits `[i*W +: W]`.
- `in_last`  in  N  end-of-packet flag per channel.
- `out_valid`  out  1  output register holds a word.
- `out_ready`  in  1  consumer accepts the output word this cycle.
- `out_data`  out  W  registered word.
- `out_last`  out  1  registered `in_last` of the accepted word.
- `out_sel`  out  SW  channel id the registered word came from.

## Operation

- Load enable: `ld = !out_valid || out_ready`.
- Candidate set is every i with `in_valid[i]`, restricted as described under Configuration.
- Grant `g` is the first candidate found scanning upward and cyclically from pointer `ptr` (`ptr`, `ptr+1`, …, N-1, 0, …).
- `in_ready` is one-hot: only `in_ready[g]` is set, and only when `ld` is high and a candidate exists. Otherwise `in_ready` is 0.
- Accept: when `in_valid[g] && in_ready[g]`:
  - `out_data`, `out_last` and `out_sel` load `in_data[g]`, `in_last[g]` and `g`.
  - `out_valid` is set to 1.
- If `ld` is high and there is no candidate, `out_valid` clears to 0 and `out_data`, `out_last` and `out_sel` hold their values.
- Pointer update on accept: `ptr <= (g == N-1) ? 0 : g+1`. The pointer wraps modulo N and never changes without an accept.
- While `out_valid && !out_ready`, all output fields are held stable and `in_ready` is 0. This is backpressure.
- Data bits, including X, pass through unmodified. Unselected channels never affect the outputs.

## Timing

- `in_ready` is combinational from `in_valid`, `out_ready`, `out_valid`, `ptr` and lock state. There is a combinational path from `out_ready` to `in_ready`.
- Latency is 1 cycle: a word accepted at edge k is visible on `out_data` with `out_valid=1` after edge k.
- Throughput is 1 word per cycle when `out_ready` is held high.
- Simultaneous output drain and input accept in the same cycle is legal: the register reloads with no bubble.
- Reset values, applied asynchronously on `rst_n=0`:
  - `out_valid=0`, `out_data=0`, `out_last=0`, `out_sel=0`.
  - `ptr=0`, lock state cleared.
  - `in_ready=0` for the whole time `rst_n` is low.
- Reset asserted mid-packet or mid-backpressure discards the held word and the lock. After release, arbitration restarts from channel 0.

## Configuration

- Macro: `MUX_N_1_RR_PACKET_LOCK_EN`.
- Defined: packet lock.
  - After accepting a word with `in_last=0` from channel g, the arbiter locks to g.
  - While locked, the candidate set is `{g}` only; other channels wait even if valid.
  - The lock releases on the accept of a word from g with `in_last=1`.
  - `ptr` advances only on that last-word accept. Non-last accepts leave `ptr` unchanged.
- Undefined: arbitration is per word.
  - `in_last` is only carried to `out_last`.
  - `ptr` advances on every accept, as described under Operation.
- Port list is identical in both builds.

## Test plan

- Reset check: `rst_n=0`, all `in_valid=1` -> `out_valid=0`, `out_data=0`, `out_sel=0`, `in_ready=0`; after release, first grant goes to channel 0.
- Round-robin fairness, N=4, W=4, per-word build: `in_data={d,c,b,a}`, all valid, `out_ready=1` -> `out_data` sequence a,b,c,d,a and `out_sel` sequence 0,1,2,3,0, one word per cycle.
- Sparse valid and wrap-around: only channels 1 and 3 valid, `ptr=2` -> grants 3,1,3,1; `out_sel` never shows 0 or 2.
- Backpressure: `out_ready=0` for 3 cycles with `out_data=5` -> `out_data` stays 5, `in_ready=4'b0000`; the cycle `out_ready` returns -> the next word loads with no bubble.
- X passthrough: channel 3 data `'x`, only channel 3 valid -> `out_data` is X, `out_sel=3`; channel 0 data=7 valid next -> `out_data=7`.
- Packet lock build: channel 0 sends 3 words with `in_last` pattern 0,0,1 while channel 1 is valid -> `out_sel` 0,0,0,1 and `out_last` 0,0,1,x; per-word build under the same stimulus -> `out_sel` 0,1,0,1.
